sm_add_arbiter: RTL

//  Shares one sign-magnitude adder between two requesters with round-robin arbitration.

---
 rtl/sm_pkg.sv | 18 +
 rtl/sm_add_arbiter_if.sv | 29 ++
 rtl/sm_add_core.sv | 52 +++++
 rtl/sm_add_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared types for the sign-magnitude add arbiter: FSM states, operand record, requester count.
package sm_pkg;

   localparam int NUM_REQ = 2;
   localparam int MAG_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } sm_state_e;

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
   } sm_operand_t;

endpackage

// File: rtl/sm_add_arbiter_if.sv
// Request/response bundle between operand producers, the arbiter and the result consumer.
interface sm_add_arbiter_if
   import sm_pkg::*;
#(
   parameter int N = MAG_W
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   req_sign_a;
   logic [NUM_REQ-1:0]   req_sign_b;
   logic [NUM_REQ*N-1:0] req_a;
   logic [NUM_REQ*N-1:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_id;
   logic                 rsp_sign;
   logic [N-1:0]         rsp_mag;
   logic                 rsp_ovf;

   modport master (
      output req_valid, req_sign_a, req_sign_b, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sign, rsp_mag, rsp_ovf
   );

   modport slave (
      input  req_valid, req_sign_a, req_sign_b, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sign, rsp_mag, rsp_ovf
   );
endinterface

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude adder; zero results are forced to +0.
// SM_ADD_SAT_EN: clamp the magnitude to all ones on same-sign overflow instead of wrapping.
module sm_add_core #(
   parameter int N = 4
) (
   input  logic         sign_a_i,
   input  logic [N-1:0] a_i,
   input  logic         sign_b_i,
   input  logic [N-1:0] b_i,
   output logic         sign_sum_o,
   output logic [N-1:0] mag_sum_o,
   output logic         ovf_o
);

   logic [N:0]   sum_s;
   logic [N-1:0] mag_s;
   logic         sign_s;
   logic         ovf_s;

   // magnitude and sign selection for like/unlike signs
   always_comb begin
      sum_s  = {1'b0, a_i} + {1'b0, b_i};
      mag_s  = {N{1'b0}};
      sign_s = 1'b0;
      ovf_s  = 1'b0;
      if (sign_a_i == sign_b_i) begin
         sign_s = sign_a_i;
         ovf_s  = sum_s[N];
`ifdef SM_ADD_SAT_EN
         if (sum_s[N]) begin
            mag_s = {N{1'b1}};
         end else begin
            mag_s = sum_s[N-1:0];
         end
`else
         mag_s = sum_s[N-1:0];
`endif
      end else if (a_i >= b_i) begin
         mag_s  = a_i - b_i;
         sign_s = sign_a_i;
      end else begin
         mag_s  = b_i - a_i;
         sign_s = sign_b_i;
      end
   end

   // a genuine zero never carries a negative sign; wrapped overflow keeps its sign
   assign sign_sum_o = sign_s & ~((mag_s == {N{1'b0}}) & ~ovf_s);
   assign mag_sum_o  = mag_s;
   assign ovf_o      = ovf_s;

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin share of one sign-magnitude adder between two requesters (IDLE/CALC/RESP).
// Optional SM_ADD_SAT_EN (see sm_add_core) saturates overflowing magnitudes.
module sm_add_arbiter
   import sm_pkg::*;
#(
   parameter int N = MAG_W
) (
   input  logic            clk,
   input  logic            rst,
   sm_add_arbiter_if.slave bus
);

   sm_state_e   state_q, state_d;
   logic        prio_q, prio_d;
   logic        id_q, id_d;
   sm_operand_t opa_q, opa_d;
   sm_operand_t opb_q, opb_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   sm_operand_t rsp_q, rsp_d;
   logic        rsp_ovf_q, rsp_ovf_d;

   logic [1:0]   grant_s;
   logic         gid_s;
   logic         sum_sign_s;
   logic [N-1:0] sum_mag_s;
   logic         sum_ovf_s;

   sm_add_core #(.N(N)) u_core (
      .sign_a_i   (opa_q.sign),
      .a_i        (opa_q.mag),
      .sign_b_i   (opb_q.sign),
      .b_i        (opb_q.mag),
      .sign_sum_o (sum_sign_s),
      .mag_sum_o  (sum_mag_s),
      .ovf_o      (sum_ovf_s)
   );

   // arbitration, next-state and register updates
   always_comb begin
      grant_s     = 2'b00;
      gid_s       = 1'b0;
      state_d     = state_q;
      prio_d      = prio_q;
      id_d        = id_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_d       = rsp_q;
      rsp_ovf_d   = rsp_ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid == 2'b11) begin
               grant_s = prio_q ? 2'b10 : 2'b01;
            end else begin
               grant_s = bus.req_valid;
            end
            gid_s = grant_s[1];
            if (grant_s != 2'b00) begin
               state_d   = CALC;
               id_d      = gid_s;
               prio_d    = ~gid_s;
               opa_d.sign = bus.req_sign_a[gid_s];
               opb_d.sign = bus.req_sign_b[gid_s];
               opa_d.mag  = gid_s ? bus.req_a[2*N-1:N] : bus.req_a[N-1:0];
               opb_d.mag  = gid_s ? bus.req_b[2*N-1:N] : bus.req_b[N-1:0];
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_d.sign  = sum_sign_s;
            rsp_d.mag   = sum_mag_s;
            rsp_ovf_d   = sum_ovf_s;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state, operand and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         id_q        <= 1'b0;
         opa_q       <= '{sign: 1'b0, mag: {MAG_W{1'b0}}};
         opb_q       <= '{sign: 1'b0, mag: {MAG_W{1'b0}}};
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_q       <= '{sign: 1'b0, mag: {MAG_W{1'b0}}};
         rsp_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         id_q        <= id_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_q       <= rsp_d;
         rsp_ovf_q   <= rsp_ovf_d;
      end
   end

   assign bus.req_ready = grant_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sign  = rsp_q.sign;
   assign bus.rsp_mag   = rsp_q.mag;
   assign bus.rsp_ovf   = rsp_ovf_q;

endmodule
